irq_pulse_ctrl: RTL and testbench

Parametrised, multi-channel successor to the single-button interrupt FSM. Each of `N_CH` request inputs (buttons or peripheral strobes) runs its own qualify/delay/re-arm state machine. A shared pulse engine arbitrates pending channels by fixed priority and emits a fixed-width `intr` pulse to the CPU together with the winning channel index. It sits between the board inputs and the MCU interrupt pin; `ch_state` is brought out for PMOD debug.

---
 rtl/irq_pulse_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_irq_pulse_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pulse_ctrl.sv
// irq_pulse_ctrl: multi-channel interrupt request qualifier with a shared pulse engine.
//
// Each request channel runs an IDLE -> DELAY -> PEND -> RELOAD state machine. A request
// must be seen for DELAY_CYCLES cycles before it becomes pending. When REQUIRE_HOLD is set,
// the input must also stay high for that whole time. Pending channels are arbitrated by
// fixed priority, with the lowest index winning. The winner is reported as a registered
// PULSE_CYCLES-wide interrupt pulse. The engine then spends one mandatory idle cycle
// before it makes the next grant.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   press     per-channel request inputs, already synchronised, active high
//   en        per-channel enable
//   intr      registered interrupt pulse to the CPU
//   intr_id   index of the serviced channel; holds its last value while intr is low
//   pend      bit i set while channel i is pending
//   ch_state  per-channel state code at bits [2i+1:2i] (0 idle, 1 delay, 2 pend, 3 reload)

module irq_pulse_ctrl #(
   parameter int unsigned N_CH         = 4,
   parameter int unsigned DELAY_CYCLES = 90908,
   parameter int unsigned PULSE_CYCLES = 6,
   parameter int unsigned REQUIRE_HOLD = 1,
   parameter int unsigned IDW          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_CH-1:0]   press,
   input  logic [N_CH-1:0]   en,
   output logic              intr,
   output logic [IDW-1:0]    intr_id,
   output logic [N_CH-1:0]   pend,
   output logic [2*N_CH-1:0] ch_state
);

   localparam int unsigned CW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
   localparam int unsigned PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

   localparam logic [CW-1:0] CntLast = CW'(DELAY_CYCLES - 1);
   localparam logic [PW-1:0] PulLast = PW'(PULSE_CYCLES - 1);

   // Channel state codes; these values are visible on ch_state.
   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StDelay  = 2'd1;
   localparam logic [1:0] StPend   = 2'd2;
   localparam logic [1:0] StReload = 2'd3;

   localparam logic [0:0] EngIdle   = 1'b0;
   localparam logic [0:0] EngActive = 1'b1;

   logic [1:0]    st_q  [N_CH];
   logic [1:0]    st_d  [N_CH];
   logic [CW-1:0] cnt_q [N_CH];
   logic [CW-1:0] cnt_d [N_CH];

   logic [0:0]     eng_q, eng_d;
   logic [PW-1:0]  pcnt_q, pcnt_d;
   logic           intr_q, intr_d;
   logic [IDW-1:0] id_q, id_d;

   logic            gnt_vld;
   logic [IDW-1:0]  gnt_idx;
   logic [N_CH-1:0] gnt;

   // Fixed-priority grant, only while the engine is idle. The scan runs from high to low,
   // so the lowest pending index is the last one written and wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      gnt     = '0;
      if (eng_q == EngIdle) begin
         for (int i = N_CH - 1; i >= 0; i--) begin
            if (pend[i]) begin
               gnt_vld = 1'b1;
               gnt_idx = IDW'(i);
               gnt     = '0;
               gnt[i]  = 1'b1;
            end
         end
      end
   end

   // Per-channel next state.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         st_d[i]  = st_q[i];
         cnt_d[i] = cnt_q[i];
         unique case (st_q[i])
            StIdle: begin
               if (press[i] && en[i]) begin
                  st_d[i]  = StDelay;
                  cnt_d[i] = '0;
               end
            end
            StDelay: begin
               if (!en[i] || ((REQUIRE_HOLD != 0) && !press[i])) begin
                  st_d[i] = StIdle;
               end else if (cnt_q[i] == CntLast) begin
                  st_d[i] = StPend;
               end else if (cnt_q[i] != '1) begin
                  // Saturating increment; the counter never wraps.
                  cnt_d[i] = cnt_q[i] + CW'(1);
               end
            end
            StPend: begin
               // A grant issued this cycle takes precedence over an enable drop.
               if (gnt[i]) begin
                  st_d[i] = StReload;
               end else if (!en[i]) begin
                  st_d[i] = StIdle;
               end
            end
            StReload: begin
               // Leave only on release, so a held input cannot re-trigger.
               if (!press[i]) begin
                  st_d[i] = StIdle;
               end
            end
            default: st_d[i] = StIdle;
         endcase
      end
   end

   // Pulse engine next state.
   always_comb begin
      eng_d  = eng_q;
      pcnt_d = pcnt_q;
      intr_d = intr_q;
      id_d   = id_q;
      unique case (eng_q)
         EngIdle: begin
            if (gnt_vld) begin
               eng_d  = EngActive;
               pcnt_d = '0;
               intr_d = 1'b1;
               id_d   = gnt_idx;
            end
         end
         EngActive: begin
            // Dropping back to idle forces the single low cycle between pulses.
            if (pcnt_q == PulLast) begin
               eng_d  = EngIdle;
               intr_d = 1'b0;
            end else begin
               pcnt_d = pcnt_q + PW'(1);
            end
         end
         default: eng_d = EngIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            st_q[i]  <= StIdle;
            cnt_q[i] <= '0;
         end
         eng_q  <= EngIdle;
         pcnt_q <= '0;
         intr_q <= 1'b0;
         id_q   <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            st_q[i]  <= st_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         eng_q  <= eng_d;
         pcnt_q <= pcnt_d;
         intr_q <= intr_d;
         id_q   <= id_d;
      end
   end

   // Outputs decoded straight from state registers.
   always_comb begin
      pend     = '0;
      ch_state = '0;
      for (int i = 0; i < N_CH; i++) begin
         pend[i]           = (st_q[i] == StPend);
         ch_state[2*i +: 2] = st_q[i];
      end
   end

   assign intr    = intr_q;
   assign intr_id = id_q;

endmodule

// File: tb/tb_irq_pulse_ctrl.sv
module tb_irq_pulse_ctrl;

   localparam int unsigned N  = 4;
   localparam int unsigned D  = 4;
   localparam int unsigned P  = 3;
   localparam int unsigned DL = 90908;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] press = '0, en = '1;
   logic         intr;
   logic [1:0]   intr_id;
   logic [N-1:0] pend;
   logic [7:0]   ch_state;

   logic [N-1:0] press_nh = '0, en_nh = '1;
   logic         intr_nh;
   logic [1:0]   intr_id_nh;
   logic [N-1:0] pend_nh;
   logic [7:0]   ch_state_nh;

   logic [N-1:0] press_l = '0, en_l = '1;
   logic         intr_l;
   logic [1:0]   intr_id_l;
   logic [N-1:0] pend_l;
   logic [7:0]   ch_state_l;

   int checks = 0;
   int errors = 0;
   int unsigned cyc = 0;

   typedef struct {
      int unsigned id;
      int unsigned cyc;
   } exp_t;
   exp_t exp_q[$];

   irq_pulse_ctrl #(.N_CH(N), .DELAY_CYCLES(D), .PULSE_CYCLES(P), .REQUIRE_HOLD(1)) dut (
      .clk(clk), .rst_n(rst_n), .press(press), .en(en), .intr(intr), .intr_id(intr_id),
      .pend(pend), .ch_state(ch_state)
   );

   irq_pulse_ctrl #(.N_CH(N), .DELAY_CYCLES(D), .PULSE_CYCLES(P), .REQUIRE_HOLD(0)) dut_nh (
      .clk(clk), .rst_n(rst_n), .press(press_nh), .en(en_nh), .intr(intr_nh),
      .intr_id(intr_id_nh), .pend(pend_nh), .ch_state(ch_state_nh)
   );

   irq_pulse_ctrl #(.N_CH(N)) dut_l (
      .clk(clk), .rst_n(rst_n), .press(press_l), .en(en_l), .intr(intr_l),
      .intr_id(intr_id_l), .pend(pend_l), .ch_state(ch_state_l)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Press driven at the negedge where cyc == k is sampled at edge k+1; intr rises D+1 later.
   task automatic expect_pulse(input int unsigned id, input int unsigned rise);
      exp_t e;
      e.id  = id;
      e.cyc = rise;
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor for the main instance: every rise pops one expectation.
   logic intr_prev = 1'b0;
   int   hi_cnt = 0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         intr_prev = 1'b0;
         hi_cnt    = 0;
      end else begin
         if (intr && !intr_prev) begin
            check("sb_pulse_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("sb_id", 32'(intr_id), e.id);
               check("sb_rise_cycle", cyc, e.cyc);
            end
            hi_cnt = 1;
         end else if (intr) begin
            hi_cnt++;
         end else if (intr_prev) begin
            check("sb_width", hi_cnt, P);
         end
         intr_prev = intr;
      end
   end

   initial begin
      int unsigned k;
      // Reset state
      #1;
      check("rst_intr", 32'(intr), 0);
      check("rst_id", 32'(intr_id), 0);
      check("rst_pend", 32'(pend), 0);
      check("rst_state", 32'(ch_state), 0);
      step(2);
      rst_n = 1'b1;
      step(2);

      // Single channel, held press
      k = cyc;
      press[2] = 1'b1;
      expect_pulse(2, k + D + 2);
      step(4);
      check("t1_delay_state", 32'(ch_state[5:4]), 1);
      check("t1_pend_early", 32'(pend), 0);
      step(1);
      check("t1_pend", 32'(pend), 32'b0100);
      step(1);
      check("t1_intr", 32'(intr), 1);
      check("t1_id", 32'(intr_id), 2);
      check("t1_reload", 32'(ch_state[5:4]), 3);
      step(3);
      check("t1_intr_fall", 32'(intr), 0);
      step(10);
      check("t1_held_reload", 32'(ch_state[5:4]), 3);
      press[2] = 1'b0;
      step(1);
      check("t1_release_idle", 32'(ch_state[5:4]), 0);
      press[2] = 1'b1;
      expect_pulse(2, cyc + D + 2);
      step(12);
      press[2] = 1'b0;
      step(2);

      // Hold qualification on both hold settings
      k = cyc;
      press[0] = 1'b1;
      press_nh[0] = 1'b1;
      step(2);
      press[0] = 1'b0;
      press_nh[0] = 1'b0;
      step(1);
      check("t2_hold_abort", 32'(ch_state[1:0]), 0);
      check("t2_nohold_delay", 32'(ch_state_nh[1:0]), 1);
      step(2);
      check("t2_nohold_pend", 32'(pend_nh), 1);
      step(1);
      check("t2_nohold_intr", 32'(intr_nh), 1);
      check("t2_nohold_id", 32'(intr_id_nh), 0);
      step(3);
      check("t2_nohold_fall", 32'(intr_nh), 0);
      check("t2_nohold_idle", 32'(ch_state_nh), 0);
      check("t2_hold_no_pend", 32'(pend), 0);
      step(4);

      // Priority: channels 1 and 3 on the same edge
      k = cyc;
      press[1] = 1'b1;
      press[3] = 1'b1;
      expect_pulse(1, k + D + 2);
      expect_pulse(3, k + D + 2 + P + 1);
      step(D + 2);
      check("t3_pend3_wait", 32'(pend), 32'b1000);
      step(2);
      check("t3_pend3_hold", 32'(pend), 32'b1000);
      step(1);
      check("t3_gap_low", 32'(intr), 0);
      step(1);
      check("t3_second_id", 32'(intr_id), 3);
      check("t3_pend_clear", 32'(pend), 0);
      step(4);
      press[1] = 1'b0;
      press[3] = 1'b0;
      step(2);

      // Enable drop while pending behind an active pulse
      k = cyc;
      press[1] = 1'b1;
      expect_pulse(1, k + D + 2);
      step(1);
      press[0] = 1'b1;
      step(6);
      check("t4_pend0_behind", 32'(pend), 32'b0001);
      en[0] = 1'b0;
      step(1);
      check("t4_cancel_pend", 32'(pend), 0);
      check("t4_cancel_idle", 32'(ch_state[1:0]), 0);
      step(6);
      check("t4_no_pulse", 32'(intr), 0);
      press[0] = 1'b0;
      en[0] = 1'b1;
      en[1] = 1'b0;
      step(1);
      check("t4_reload_ignores_en", 32'(ch_state[3:2]), 3);
      press[1] = 1'b0;
      step(1);
      check("t4_rearm_idle", 32'(ch_state[3:2]), 0);
      en[1] = 1'b1;
      press[1] = 1'b1;
      expect_pulse(1, cyc + D + 2);
      step(10);
      press[1] = 1'b0;
      step(2);

      // Reset during the second cycle of a pulse with another channel pending
      k = cyc;
      press[2] = 1'b1;
      press[3] = 1'b1;
      expect_pulse(2, k + D + 2);
      step(D + 3);
      check("t5_pre_pend", 32'(pend), 32'b1000);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_intr", 32'(intr), 0);
      check("t5_rst_pend", 32'(pend), 0);
      check("t5_rst_state", 32'(ch_state), 0);
      press = '0;
      step(2);
      #2;
      rst_n = 1'b1;
      step(12);
      check("t5_no_resume", 32'(intr), 0);
      check("t5_idle_after", 32'(ch_state), 0);
      press[3] = 1'b1;
      expect_pulse(3, cyc + D + 2);
      step(10);
      press[3] = 1'b0;
      step(2);
      check("sb_drained", exp_q.size(), 0);

      // Long default delay
      k = cyc;
      press_l[0] = 1'b1;
      step(DL + 1);
      check("t6_long_pend", 32'(pend_l), 1);
      check("t6_long_low", 32'(intr_l), 0);
      step(1);
      check("t6_long_rise", 32'(intr_l), 1);
      check("t6_long_latency", cyc - k, DL + 2);
      press_l[0] = 1'b0;
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
